// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter: FSM states, access owner and the
// latched SRAM request handed to the timing controller.
package sram_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DATA = 2'd1,
        OWN_INST = 2'd2
    } owner_t;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic               wen;
        logic [3:0]         byte_sel;
        logic [DATA_W-1:0]  wdata;
    } sram_req_t;

    // Byte address to 32-bit word address; the top truncates to SRAM_AW.
    function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Pipeline- and SRAM-side signal bundle of the arbiter. The arbiter uses the
// slave modport; the surrounding pipeline/SRAM (or a bench) uses master.
interface sram_bus_arbiter_if #(
    parameter int SRAM_AW = 20
);
    logic               IF_REQ;
    logic [31:0]        IF_ADDR;
    logic [31:0]        IF_RDATA;
    logic               IF_RDY;
    logic               MEM_CEN;
    logic               MEM_WEN;
    logic [31:0]        MEM_ADDR;
    logic [3:0]         MEM_BYTE_SEL;
    logic [31:0]        MEM_SDATA;
    logic [31:0]        MEM_LDATA;
    logic               MEM_RDY;
    logic               STALL_REQ;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [31:0]        SRAM_WDATA;
    logic [31:0]        SRAM_RDATA;
    logic               SRAM_CE_N;
    logic               SRAM_OE_N;
    logic               SRAM_WE_N;
    logic [3:0]         SRAM_BE_N;

    modport slave (
        input  IF_REQ, IF_ADDR, MEM_CEN, MEM_WEN, MEM_ADDR, MEM_BYTE_SEL,
               MEM_SDATA, SRAM_RDATA,
        output IF_RDATA, IF_RDY, MEM_LDATA, MEM_RDY, STALL_REQ, SRAM_ADDR,
               SRAM_WDATA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N
    );

    modport master (
        output IF_REQ, IF_ADDR, MEM_CEN, MEM_WEN, MEM_ADDR, MEM_BYTE_SEL,
               MEM_SDATA, SRAM_RDATA,
        input  IF_RDATA, IF_RDY, MEM_LDATA, MEM_RDY, STALL_REQ, SRAM_ADDR,
               SRAM_WDATA, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N
    );
endinterface

// File: rtl/sram_bus_arbiter_timing_ctrl.sv
// SRAM access sequencer: latches one request on start, drives registered
// strobes for WAIT_CYCLES+1 cycles and flags the last access cycle.
module sram_timing_ctrl
    import sram_arb_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  sram_req_t          req_in,
    output sram_req_t          cur_req,
    output logic               last,
    output logic               ce_n,
    output logic               oe_n,
    output logic               we_n,
    output logic [3:0]         be_n,
    output logic [SRAM_AW-1:0] addr,
    output logic [31:0]        wdata
);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    sram_req_t  req_d, req_q;
    logic       active_d, active_q;
    logic [3:0] cnt_d, cnt_q;
    logic       ce_n_d, ce_n_q, oe_n_d, oe_n_q, we_n_d, we_n_q;
    logic [3:0] be_n_d, be_n_q;

    // Next-state and strobe computation; strobes reflect the cycle being entered.
    always_comb begin
        req_d    = req_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        be_n_d   = 4'b1111;
        if (start) begin
            req_d    = req_in;
            active_d = 1'b1;
            cnt_d    = 4'd0;
            ce_n_d   = 1'b0;
            oe_n_d   = req_in.wen;
            we_n_d   = ~req_in.wen;
            be_n_d   = ~req_in.byte_sel;
        end else if (active_q) begin
            if (cnt_q == LAST_CNT) begin
                active_d = 1'b0;
                cnt_d    = 4'd0;
            end else begin
                cnt_d  = cnt_q + 4'd1;
                ce_n_d = 1'b0;
                oe_n_d = req_q.wen;
                // Write strobe is released for the final cycle to give data hold time.
                we_n_d = ~(req_q.wen && (cnt_d != LAST_CNT));
                be_n_d = ~req_q.byte_sel;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // State and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= 4'b1111;
        end else begin
            req_q    <= req_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
        end
    end

    assign cur_req = req_q;
    assign last    = active_q && (cnt_q == LAST_CNT);
    assign ce_n    = ce_n_q;
    assign oe_n    = oe_n_q;
    assign we_n    = we_n_q;
    assign be_n    = be_n_q;
    assign addr    = req_q.addr[SRAM_AW-1:0];
    assign wdata   = req_q.wdata;
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM between instruction fetch and the data port (data first).
// Optional one-entry fetch buffer: define SRAM_ARB_INST_BUF_EN.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    sram_bus_arbiter_if.slave bus
);
    arb_state_t  state_d, state_q;
    owner_t      owner_d, owner_q;
    logic [31:0] if_rdata_d, if_rdata_q, mem_ldata_d, mem_ldata_q;
    logic        if_rdy_d, if_rdy_q, mem_rdy_d, mem_rdy_q;
    logic        start_s, last_s;
    sram_req_t   req_s, cur_req_s;

`ifdef SRAM_ARB_INST_BUF_EN
    logic               buf_valid_d, buf_valid_q;
    logic [WADDR_W-1:0] buf_tag_d, buf_tag_q;
    logic [31:0]        buf_data_d, buf_data_q;
    logic               buf_hit_s;
    assign buf_hit_s = buf_valid_q && (buf_tag_q == word_addr(bus.IF_ADDR));
`endif

    // Requester selection, completion capture and RDY generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        if_rdata_d  = if_rdata_q;
        mem_ldata_d = mem_ldata_q;
        if_rdy_d    = 1'b0;
        mem_rdy_d   = 1'b0;
        start_s     = 1'b0;
        req_s       = '0;
`ifdef SRAM_ARB_INST_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.MEM_CEN) begin
                    req_s.addr     = word_addr(bus.MEM_ADDR);
                    req_s.wen      = bus.MEM_WEN;
                    req_s.byte_sel = bus.MEM_BYTE_SEL;
                    req_s.wdata    = bus.MEM_SDATA;
                    start_s        = 1'b1;
                    owner_d        = OWN_DATA;
                    state_d        = ACCESS;
                end else if (bus.IF_REQ) begin
                    req_s.addr     = word_addr(bus.IF_ADDR);
                    req_s.wen      = 1'b0;
                    req_s.byte_sel = 4'b1111;
                    req_s.wdata    = 32'h0000_0000;
                    owner_d        = OWN_INST;
`ifdef SRAM_ARB_INST_BUF_EN
                    if (buf_hit_s) begin
                        if_rdata_d = buf_data_q;
                        if_rdy_d   = 1'b1;
                        state_d    = DONE;
                    end else begin
                        start_s = 1'b1;
                        state_d = ACCESS;
                    end
`else
                    start_s = 1'b1;
                    state_d = ACCESS;
`endif
                end else begin
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (last_s) begin
                    state_d = DONE;
                    if (owner_q == OWN_DATA) begin
                        mem_rdy_d = 1'b1;
                        // Stores leave the load register untouched.
                        if (!cur_req_s.wen) begin
                            mem_ldata_d = bus.SRAM_RDATA;
                        end else begin
                            mem_ldata_d = mem_ldata_q;
                        end
`ifdef SRAM_ARB_INST_BUF_EN
                        if (cur_req_s.wen && (cur_req_s.addr == buf_tag_q)) begin
                            buf_valid_d = 1'b0;
                        end else begin
                            buf_valid_d = buf_valid_q;
                        end
`endif
                    end else if (owner_q == OWN_INST) begin
                        if_rdy_d   = 1'b1;
                        if_rdata_d = bus.SRAM_RDATA;
`ifdef SRAM_ARB_INST_BUF_EN
                        buf_valid_d = 1'b1;
                        buf_tag_d   = cur_req_s.addr;
                        buf_data_d  = bus.SRAM_RDATA;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter registers; reset mid-access drops the access with no RDY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            if_rdata_q  <= 32'h0000_0000;
            mem_ldata_q <= 32'h0000_0000;
            if_rdy_q    <= 1'b0;
            mem_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_rdata_q  <= if_rdata_d;
            mem_ldata_q <= mem_ldata_d;
            if_rdy_q    <= if_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
        end
    end

`ifdef SRAM_ARB_INST_BUF_EN
    // Fetch buffer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= 32'h0000_0000;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    sram_timing_ctrl #(
        .SRAM_AW     (SRAM_AW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timing (
        .clk     (CLK),
        .rst     (RST),
        .start   (start_s),
        .req_in  (req_s),
        .cur_req (cur_req_s),
        .last    (last_s),
        .ce_n    (bus.SRAM_CE_N),
        .oe_n    (bus.SRAM_OE_N),
        .we_n    (bus.SRAM_WE_N),
        .be_n    (bus.SRAM_BE_N),
        .addr    (bus.SRAM_ADDR),
        .wdata   (bus.SRAM_WDATA)
    );

    assign bus.IF_RDATA  = if_rdata_q;
    assign bus.IF_RDY    = if_rdy_q;
    assign bus.MEM_LDATA = mem_ldata_q;
    assign bus.MEM_RDY   = mem_rdy_q;
    // Drops in the RDY cycle so the pipeline advances on that edge.
    assign bus.STALL_REQ = (bus.MEM_CEN && !mem_rdy_q) || (bus.IF_REQ && !if_rdy_q);
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with WAIT_CYCLES=1 and a small SRAM model.
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_sram_bus_arbiter;
    localparam int SRAM_AW = 20;

    logic CLK;
    logic RST;
    int   test_cnt;
    int   fail_cnt;
    logic [31:0] mem [0:255];

    sram_bus_arbiter_if #(.SRAM_AW(SRAM_AW)) bus_if ();

    sram_bus_arbiter #(.SRAM_AW(SRAM_AW), .WAIT_CYCLES(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Asynchronous-read SRAM; writes committed at each clock edge while WE_N is low.
    assign bus_if.SRAM_RDATA = (!bus_if.SRAM_CE_N && !bus_if.SRAM_OE_N) ?
                               mem[bus_if.SRAM_ADDR[7:0]] : 32'h0000_0000;
    always @(posedge CLK) begin
        if (!bus_if.SRAM_CE_N && !bus_if.SRAM_WE_N) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus_if.SRAM_BE_N[b]) mem[bus_if.SRAM_ADDR[7:0]][8*b +: 8] <= bus_if.SRAM_WDATA[8*b +: 8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.IF_REQ       = 1'b0;
        bus_if.IF_ADDR      = 32'h0;
        bus_if.MEM_CEN      = 1'b0;
        bus_if.MEM_WEN      = 1'b0;
        bus_if.MEM_ADDR     = 32'h0;
        bus_if.MEM_BYTE_SEL = 4'h0;
        bus_if.MEM_SDATA    = 32'h0;
    endtask

    task automatic mem_req(input logic wen, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] sdata);
        bus_if.MEM_CEN      = 1'b1;
        bus_if.MEM_WEN      = wen;
        bus_if.MEM_ADDR     = addr;
        bus_if.MEM_BYTE_SEL = sel;
        bus_if.MEM_SDATA    = sdata;
    endtask

    initial begin
        test_cnt = 0;
        fail_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;
        mem[5]  = 32'hCAFE_F00D;
        mem[8]  = 32'h1122_3344;
        mem[16] = 32'hA5A5_A5A5;
        mem[64] = 32'h600D_F00D;
        idle_inputs();
        RST = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_ce_n", {31'h0, bus_if.SRAM_CE_N}, 32'h1);
        check("rst_oe_n", {31'h0, bus_if.SRAM_OE_N}, 32'h1);
        check("rst_we_n", {31'h0, bus_if.SRAM_WE_N}, 32'h1);
        check("rst_be_n", {28'h0, bus_if.SRAM_BE_N}, 32'hF);
        check("rst_addr", {12'h0, bus_if.SRAM_ADDR}, 32'h0);
        check("rst_wdata", bus_if.SRAM_WDATA, 32'h0);
        check("rst_ldata", bus_if.MEM_LDATA, 32'h0);
        check("rst_rdata", bus_if.IF_RDATA, 32'h0);
        check("rst_rdys", {30'h0, bus_if.IF_RDY, bus_if.MEM_RDY}, 32'h0);
        check("rst_stall", {31'h0, bus_if.STALL_REQ}, 32'h0);
        RST = 1'b0;
        tick();

        // Load from byte 0x10 (word 4)
        mem_req(1'b0, 32'h10, 4'hF, 32'h0);
        #1 check("ld_stall_c0", {31'h0, bus_if.STALL_REQ}, 32'h1);
        tick();
        check("ld_ce_c1", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        check("ld_oe_c1", {31'h0, bus_if.SRAM_OE_N}, 32'h0);
        check("ld_we_c1", {31'h0, bus_if.SRAM_WE_N}, 32'h1);
        check("ld_addr_c1", {12'h0, bus_if.SRAM_ADDR}, 32'h4);
        check("ld_stall_c1", {31'h0, bus_if.STALL_REQ}, 32'h1);
        check("ld_rdy_c1", {31'h0, bus_if.MEM_RDY}, 32'h0);
        tick();
        check("ld_oe_c2", {31'h0, bus_if.SRAM_OE_N}, 32'h0);
        check("ld_addr_c2", {12'h0, bus_if.SRAM_ADDR}, 32'h4);
        check("ld_stall_c2", {31'h0, bus_if.STALL_REQ}, 32'h1);
        tick();
        check("ld_rdy_c3", {31'h0, bus_if.MEM_RDY}, 32'h1);
        check("ld_data_c3", bus_if.MEM_LDATA, 32'hDEAD_BEEF);
        check("ld_oe_c3", {31'h0, bus_if.SRAM_OE_N}, 32'h1);
        check("ld_ce_c3", {31'h0, bus_if.SRAM_CE_N}, 32'h1);
        check("ld_stall_c3", {31'h0, bus_if.STALL_REQ}, 32'h0);
        idle_inputs();
        tick();
        check("ld_rdy_c4", {31'h0, bus_if.MEM_RDY}, 32'h0);
        check("ld_hold_c4", bus_if.MEM_LDATA, 32'hDEAD_BEEF);

        // Byte store to 0x22, lane 2
        mem_req(1'b1, 32'h22, 4'b0100, 32'h5A5A_5A5A);
        tick();
        check("st_addr_c1", {12'h0, bus_if.SRAM_ADDR}, 32'h8);
        check("st_be_c1", {28'h0, bus_if.SRAM_BE_N}, 32'hB);
        check("st_we_c1", {31'h0, bus_if.SRAM_WE_N}, 32'h0);
        check("st_oe_c1", {31'h0, bus_if.SRAM_OE_N}, 32'h1);
        check("st_wdata_c1", bus_if.SRAM_WDATA, 32'h5A5A_5A5A);
        tick();
        check("st_we_c2", {31'h0, bus_if.SRAM_WE_N}, 32'h1);
        check("st_ce_c2", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        check("st_be_c2", {28'h0, bus_if.SRAM_BE_N}, 32'hB);
        tick();
        check("st_rdy_c3", {31'h0, bus_if.MEM_RDY}, 32'h1);
        check("st_ldata_hold", bus_if.MEM_LDATA, 32'hDEAD_BEEF);
        idle_inputs();
        tick();
        check("st_mem8", mem[8], 32'h115A_3344);
        mem_req(1'b0, 32'h20, 4'hF, 32'h0);
        repeat (3) tick();
        check("rb_rdy", {31'h0, bus_if.MEM_RDY}, 32'h1);
        check("rb_data", bus_if.MEM_LDATA, 32'h115A_3344);
        idle_inputs();
        tick();

        // Simultaneous data load and fetch: data first, fetch IF_RDY at cycle 7
        mem_req(1'b0, 32'h10, 4'hF, 32'h0);
        bus_if.IF_REQ  = 1'b1;
        bus_if.IF_ADDR = 32'h14;
        #1 check("both_stall_c0", {31'h0, bus_if.STALL_REQ}, 32'h1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("both_mrdy_c%0d", c), {31'h0, bus_if.MEM_RDY}, (c == 3) ? 32'h1 : 32'h0);
            check($sformatf("both_irdy_c%0d", c), {31'h0, bus_if.IF_RDY}, (c == 7) ? 32'h1 : 32'h0);
            if (c == 3) begin
                check("both_ldata", bus_if.MEM_LDATA, 32'hDEAD_BEEF);
                bus_if.MEM_CEN = 1'b0;
            end
            if (c == 4) check("both_idle_ce", {31'h0, bus_if.SRAM_CE_N}, 32'h1);
            if (c == 5) begin
                check("both_f_ce", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
                check("both_f_addr", {12'h0, bus_if.SRAM_ADDR}, 32'h5);
            end
            if (c == 7) check("both_rdata", bus_if.IF_RDATA, 32'hCAFE_F00D);
            #1 check($sformatf("both_stall_c%0d", c), {31'h0, bus_if.STALL_REQ}, (c == 7) ? 32'h0 : 32'h1);
        end
        idle_inputs();
        tick();

        // Reset in second ACCESS cycle of a store
        mem_req(1'b1, 32'h30, 4'hF, 32'h1234_5678);
        tick();
        check("rs_we_c1", {31'h0, bus_if.SRAM_WE_N}, 32'h0);
        tick();
        check("rs_ce_c2", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        RST = 1'b1;
        tick();
        check("rs_we", {31'h0, bus_if.SRAM_WE_N}, 32'h1);
        check("rs_ce", {31'h0, bus_if.SRAM_CE_N}, 32'h1);
        check("rs_be", {28'h0, bus_if.SRAM_BE_N}, 32'hF);
        check("rs_rdy", {31'h0, bus_if.MEM_RDY}, 32'h0);
        check("rs_addr", {12'h0, bus_if.SRAM_ADDR}, 32'h0);
        check("rs_wdata", bus_if.SRAM_WDATA, 32'h0);
        check("rs_ldata", bus_if.MEM_LDATA, 32'h0);
        check("rs_rdata", bus_if.IF_RDATA, 32'h0);
        idle_inputs();
        RST = 1'b0;
        tick();
        check("rs_rdy_after", {31'h0, bus_if.MEM_RDY}, 32'h0);
        check("rs_ce_after", {31'h0, bus_if.SRAM_CE_N}, 32'h1);

        // Store with no byte lanes selected
        mem_req(1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF);
        tick();
        check("bz_be_c1", {28'h0, bus_if.SRAM_BE_N}, 32'hF);
        check("bz_ce_c1", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        tick();
        check("bz_be_c2", {28'h0, bus_if.SRAM_BE_N}, 32'hF);
        check("bz_rdy_c2", {31'h0, bus_if.MEM_RDY}, 32'h0);
        tick();
        check("bz_rdy_c3", {31'h0, bus_if.MEM_RDY}, 32'h1);
        idle_inputs();
        tick();
        check("bz_mem16", mem[16], 32'hA5A5_A5A5);

        // Fetch 0x100 twice, then store to it and fetch again
        bus_if.IF_REQ  = 1'b1;
        bus_if.IF_ADDR = 32'h100;
        repeat (3) tick();
        check("f1_rdy", {31'h0, bus_if.IF_RDY}, 32'h1);
        check("f1_data", bus_if.IF_RDATA, 32'h600D_F00D);
        idle_inputs();
        tick();
        bus_if.IF_REQ  = 1'b1;
        bus_if.IF_ADDR = 32'h100;
        tick();
`ifdef SRAM_ARB_INST_BUF_EN
        check("f2_hit_rdy", {31'h0, bus_if.IF_RDY}, 32'h1);
        check("f2_hit_ce", {31'h0, bus_if.SRAM_CE_N}, 32'h1);
        check("f2_hit_data", bus_if.IF_RDATA, 32'h600D_F00D);
`else
        check("f2_ce_c1", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        check("f2_rdy_c1", {31'h0, bus_if.IF_RDY}, 32'h0);
        repeat (2) tick();
        check("f2_rdy_c3", {31'h0, bus_if.IF_RDY}, 32'h1);
        check("f2_data", bus_if.IF_RDATA, 32'h600D_F00D);
`endif
        idle_inputs();
        tick();
        mem_req(1'b1, 32'h100, 4'hF, 32'h0BAD_C0DE);
        repeat (3) tick();
        check("f_st_rdy", {31'h0, bus_if.MEM_RDY}, 32'h1);
        idle_inputs();
        tick();
        bus_if.IF_REQ  = 1'b1;
        bus_if.IF_ADDR = 32'h100;
        tick();
        check("f3_ce_c1", {31'h0, bus_if.SRAM_CE_N}, 32'h0);
        check("f3_rdy_c1", {31'h0, bus_if.IF_RDY}, 32'h0);
        repeat (2) tick();
        check("f3_rdy_c3", {31'h0, bus_if.IF_RDY}, 32'h1);
        check("f3_data", bus_if.IF_RDATA, 32'h0BAD_C0DE);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
